// File: rtl/ddr3_req_queue.sv
// In-order request buffer between application logic and the DDR3L controller user port.
// One request is presented at a time; read returns are forwarded in order and protocol errors are latched.
module ddr3_req_queue #(
    parameter int DEPTH      = 8,
    parameter int MAX_RD_OUT = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic         clk_100mhz,
    input  logic         rst_n,
    input  logic         app_cmd_valid,
    output logic         app_cmd_ready,
    input  logic         app_cmd_we,
    input  logic [26:0]  app_addr,
    input  logic [127:0] app_wdata,
    input  logic [15:0]  app_mask,
    output logic [127:0] app_rd_data,
    output logic         app_rd_valid,
    output logic [26:0]  ctrl_addr,
    output logic [127:0] ctrl_wdata,
    output logic [15:0]  ctrl_mask,
    output logic         ctrl_rd_req,
    output logic         ctrl_wr_req,
    input  logic         ctrl_ready,
    input  logic [127:0] ctrl_rdata,
    input  logic         ctrl_rd_valid,
    output logic [3:0]   q_level,
    output logic [3:0]   rd_outstanding,
    output logic         err_timeout,
    output logic         err_unexp_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    DEPTH_L   = 4'(DEPTH);
    localparam logic [3:0]    MAX_RD_L  = 4'(MAX_RD_OUT);
    localparam logic [CW-1:0] TIMEOUT_L = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_RDY} state_t;

    // Address LSBs are never stored: bursts are always BL8-aligned on the controller side.
    typedef struct packed {
        logic         we;
        logic [23:0]  addr_hi;
        logic [127:0] wdata;
        logic [15:0]  mask;
    } entry_t;

    entry_t         entry_q [DEPTH];
    entry_t         head;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]     level_q, level_d;
    logic           ready_q, ready_d;
    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [26:0]    ctrl_addr_q, ctrl_addr_d;
    logic [127:0]   ctrl_wdata_q, ctrl_wdata_d;
    logic [15:0]    ctrl_mask_q, ctrl_mask_d;
    logic           ctrl_rd_req_q, ctrl_rd_req_d;
    logic           ctrl_wr_req_q, ctrl_wr_req_d;
    logic [3:0]     rd_out_q, rd_out_d;
    logic [127:0]   app_rd_data_q, app_rd_data_d;
    logic           app_rd_valid_q, app_rd_valid_d;
    logic           err_timeout_q, err_timeout_d;
    logic           err_unexp_q, err_unexp_d;
    logic           push, pop, rd_accept, rd_ret;
    logic           unused_addr_lsb;

    assign unused_addr_lsb = ^app_addr[2:0];
    assign push = app_cmd_valid && ready_q;
    assign head = entry_q[rd_ptr_q];
    assign rd_ret = ctrl_rd_valid && (rd_out_q != '0);

    // Payload storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk_100mhz) begin
        if (push) begin
            entry_q[wr_ptr_q] <= '{we: app_cmd_we, addr_hi: app_addr[26:3],
                                   wdata: app_wdata, mask: app_mask};
        end
    end

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wait_cnt_d    = wait_cnt_q;
        ctrl_addr_d   = ctrl_addr_q;
        ctrl_wdata_d  = ctrl_wdata_q;
        ctrl_mask_d   = ctrl_mask_q;
        ctrl_rd_req_d = ctrl_rd_req_q;
        ctrl_wr_req_d = ctrl_wr_req_q;
        err_timeout_d = err_timeout_q;
        pop           = 1'b0;
        rd_accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((level_q != '0) && ctrl_ready && (head.we || (rd_out_q < MAX_RD_L))) begin
                    pop           = 1'b1;
                    rd_ptr_d      = rd_ptr_q + AW'(1);
                    ctrl_addr_d   = {head.addr_hi, 3'b000};
                    ctrl_wdata_d  = head.wdata;
                    ctrl_mask_d   = head.mask;
                    ctrl_rd_req_d = !head.we;
                    ctrl_wr_req_d = head.we;
                    wait_cnt_d    = '0;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                // The controller signals acceptance by dropping its level-style ready.
                if (!ctrl_ready) begin
                    ctrl_rd_req_d = 1'b0;
                    ctrl_wr_req_d = 1'b0;
                    rd_accept     = ctrl_rd_req_q;
                    state_d       = ST_WAIT_RDY;
                end else if (wait_cnt_q != TIMEOUT_L) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                    if (wait_cnt_q == TO_LAST) begin
                        err_timeout_d = 1'b1;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (ctrl_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
        // Ready is registered from the next level, so a pop while full opens the slot one cycle later.
        ready_d        = (level_d < DEPTH_L);
        rd_out_d       = rd_out_q + {3'b000, rd_accept} - {3'b000, rd_ret};
        app_rd_valid_d = rd_ret;
        app_rd_data_d  = rd_ret ? ctrl_rdata : app_rd_data_q;
        err_unexp_d    = err_unexp_q | (ctrl_rd_valid && (rd_out_q == '0));
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            ready_q        <= 1'b1;
            state_q        <= ST_IDLE;
            wait_cnt_q     <= '0;
            ctrl_addr_q    <= '0;
            ctrl_wdata_q   <= '0;
            ctrl_mask_q    <= '0;
            ctrl_rd_req_q  <= 1'b0;
            ctrl_wr_req_q  <= 1'b0;
            rd_out_q       <= '0;
            app_rd_data_q  <= '0;
            app_rd_valid_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_unexp_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            ready_q        <= ready_d;
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            ctrl_addr_q    <= ctrl_addr_d;
            ctrl_wdata_q   <= ctrl_wdata_d;
            ctrl_mask_q    <= ctrl_mask_d;
            ctrl_rd_req_q  <= ctrl_rd_req_d;
            ctrl_wr_req_q  <= ctrl_wr_req_d;
            rd_out_q       <= rd_out_d;
            app_rd_data_q  <= app_rd_data_d;
            app_rd_valid_q <= app_rd_valid_d;
            err_timeout_q  <= err_timeout_d;
            err_unexp_q    <= err_unexp_d;
        end
    end

    assign app_cmd_ready  = ready_q;
    assign app_rd_data    = app_rd_data_q;
    assign app_rd_valid   = app_rd_valid_q;
    assign ctrl_addr      = ctrl_addr_q;
    assign ctrl_wdata     = ctrl_wdata_q;
    assign ctrl_mask      = ctrl_mask_q;
    assign ctrl_rd_req    = ctrl_rd_req_q;
    assign ctrl_wr_req    = ctrl_wr_req_q;
    assign q_level        = level_q;
    assign rd_outstanding = rd_out_q;
    assign err_timeout    = err_timeout_q;
    assign err_unexp_rd   = err_unexp_q;

endmodule
